// File: rtl/ibex_rvfi_pkg.sv
// Record types shared by the RVFI retirement generator, its FIFO and its bus interface.
// Build option RVFI_MEM_EN: when defined, memory fields are stored in the FIFO and forwarded.
package ibex_rvfi_pkg;

    localparam logic [1:0] RVFI_MODE = 2'b11;
    localparam logic [1:0] RVFI_IXL  = 2'b01;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rs3_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rs3_rdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
    } rvfi_issue_t;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rs3_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rs3_rdata;
    } rvfi_core_t;

    typedef struct packed {
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
    } rvfi_mem_t;

`ifdef RVFI_MEM_EN
    typedef struct packed {
        rvfi_core_t core;
        rvfi_mem_t  mem;
    } rvfi_entry_t;
`else
    typedef struct packed {
        rvfi_core_t core;
    } rvfi_entry_t;
`endif

    typedef struct packed {
        logic [31:0] insn;
        logic        trap;
        logic [1:0]  mode;
        logic [1:0]  ixl;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rs3_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rs3_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_rec_t;

    // x0 is hardwired, so a write to it never reports data.
    function automatic logic [31:0] rd_wdata_sel(logic [4:0] addr, logic [31:0] data);
        return (addr == 5'd0) ? 32'd0 : data;
    endfunction

endpackage

// File: rtl/ibex_rvfi_gen_if.sv
// Issue, writeback, flush and RVFI output signals of the retirement generator.
// Issue handshake: a record transfers on a cycle with issue_valid_i && issue_ready_o; ready depends only on registered occupancy.
interface ibex_rvfi_gen_if;
    import ibex_rvfi_pkg::*;

    logic        issue_valid_i;
    logic        issue_ready_o;
    rvfi_issue_t issue_rec_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_wdata_i;
    logic [31:0] wb_mem_rdata_i;
    logic        flush_i;
    logic        rvfi_valid_o;
    logic [63:0] rvfi_order_o;
    rvfi_rec_t   rvfi_rec_o;
    logic        err_o;

    modport master (
        output issue_valid_i, issue_rec_i, wb_valid_i, wb_rd_addr_i, wb_rd_wdata_i,
               wb_mem_rdata_i, flush_i,
        input  issue_ready_o, rvfi_valid_o, rvfi_order_o, rvfi_rec_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_rec_i, wb_valid_i, wb_rd_addr_i, wb_rd_wdata_i,
               wb_mem_rdata_i, flush_i,
        output issue_ready_o, rvfi_valid_o, rvfi_order_o, rvfi_rec_o, err_o
    );

endinterface

// File: rtl/ibex_rvfi_fifo.sv
// Count-based in-flight instruction FIFO; DEPTH must be a power of two so pointers wrap freely.
module ibex_rvfi_fifo
    import ibex_rvfi_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  rvfi_entry_t            wdata_i,
    output rvfi_entry_t            rdata_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rvfi_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PW'(1);
            if (pop_i)  rptr_d = rptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ibex_rvfi_gen.sv
// Pairs issued instruction records with their writeback and emits one registered RVFI retirement.
// Build option RVFI_MEM_EN: carries mem_* fields through; otherwise they read as zero.
module ibex_rvfi_gen
    import ibex_rvfi_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input logic            clk_i,
    input logic            rst_ni,
    ibex_rvfi_gen_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    rvfi_entry_t   wr_entry;
    rvfi_entry_t   head;
    logic          empty;
    logic [CW-1:0] count;
    logic          push;
    logic          retire;
    logic          wb_err;
    logic [4:0]    rd_addr;
    rvfi_rec_t     rec_d, rec_q;
    logic          valid_q;
    logic          err_q;
    logic [63:0]   order_q;
    logic [63:0]   order_cnt_q;

    // Issues in a flush cycle are dropped; a trap head retires on its own.
    assign push   = bus.issue_valid_i && bus.issue_ready_o && !bus.flush_i;
    assign retire = !empty && (bus.wb_valid_i || head.core.trap);
    assign wb_err = bus.wb_valid_i && (empty || head.core.trap);

    always_comb begin
        wr_entry                = '0;
        wr_entry.core.pc_rdata  = bus.issue_rec_i.pc_rdata;
        wr_entry.core.pc_wdata  = bus.issue_rec_i.pc_wdata;
        wr_entry.core.insn      = bus.issue_rec_i.insn;
        wr_entry.core.trap      = bus.issue_rec_i.trap;
        wr_entry.core.rs1_addr  = bus.issue_rec_i.rs1_addr;
        wr_entry.core.rs2_addr  = bus.issue_rec_i.rs2_addr;
        wr_entry.core.rs3_addr  = bus.issue_rec_i.rs3_addr;
        wr_entry.core.rs1_rdata = bus.issue_rec_i.rs1_rdata;
        wr_entry.core.rs2_rdata = bus.issue_rec_i.rs2_rdata;
        wr_entry.core.rs3_rdata = bus.issue_rec_i.rs3_rdata;
`ifdef RVFI_MEM_EN
        wr_entry.mem.mem_addr   = bus.issue_rec_i.mem_addr;
        wr_entry.mem.mem_rmask  = bus.issue_rec_i.mem_rmask;
        wr_entry.mem.mem_wmask  = bus.issue_rec_i.mem_wmask;
        wr_entry.mem.mem_wdata  = bus.issue_rec_i.mem_wdata;
`endif
    end

`ifndef RVFI_MEM_EN
    logic unused_mem;
    assign unused_mem = ^{bus.wb_mem_rdata_i, bus.issue_rec_i.mem_addr, bus.issue_rec_i.mem_rmask,
                          bus.issue_rec_i.mem_wmask, bus.issue_rec_i.mem_wdata};
`endif

    ibex_rvfi_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (retire),
        .flush_i (bus.flush_i),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        rd_addr         = head.core.trap ? 5'd0 : bus.wb_rd_addr_i;
        rec_d           = '0;
        rec_d.insn      = head.core.insn;
        rec_d.trap      = head.core.trap;
        rec_d.mode      = RVFI_MODE;
        rec_d.ixl       = RVFI_IXL;
        rec_d.rs1_addr  = head.core.rs1_addr;
        rec_d.rs2_addr  = head.core.rs2_addr;
        rec_d.rs3_addr  = head.core.rs3_addr;
        rec_d.rs1_rdata = head.core.rs1_rdata;
        rec_d.rs2_rdata = head.core.rs2_rdata;
        rec_d.rs3_rdata = head.core.rs3_rdata;
        rec_d.rd_addr   = rd_addr;
        rec_d.rd_wdata  = rd_wdata_sel(rd_addr, bus.wb_rd_wdata_i);
        rec_d.pc_rdata  = head.core.pc_rdata;
        rec_d.pc_wdata  = head.core.pc_wdata;
`ifdef RVFI_MEM_EN
        rec_d.mem_addr  = head.mem.mem_addr;
        rec_d.mem_rmask = head.mem.mem_rmask;
        rec_d.mem_wmask = head.mem.mem_wmask;
        rec_d.mem_wdata = head.mem.mem_wdata;
        rec_d.mem_rdata = head.core.trap ? 32'd0 : bus.wb_mem_rdata_i;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            order_q     <= '0;
            order_cnt_q <= '0;
            rec_q       <= '0;
        end else begin
            valid_q <= retire;
            err_q   <= err_q | wb_err;
            if (retire) begin
                rec_q       <= rec_d;
                order_q     <= order_cnt_q;
                order_cnt_q <= order_cnt_q + 64'd1;
            end
        end
    end

    assign bus.issue_ready_o = (count < CW'(DEPTH));
    assign bus.rvfi_valid_o  = valid_q;
    assign bus.rvfi_order_o  = order_q;
    assign bus.rvfi_rec_o    = rec_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_ibex_rvfi_gen.sv
// Directed plus randomized bench for ibex_rvfi_gen against a queue-based model of in-flight instructions.
module tb_ibex_rvfi_gen;
    import ibex_rvfi_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_rvfi_gen_if bus ();

    ibex_rvfi_gen #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    rvfi_issue_t pend[$];
    logic [63:0] m_ord;
    logic [63:0] m_order_out;
    bit          m_err;
    bit          m_valid;
    rvfi_rec_t   m_rec;
    logic [63:0] n_save;
    rvfi_issue_t tmp;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.issue_valid_i  = 1'b0;
        bus.issue_rec_i    = '0;
        bus.wb_valid_i     = 1'b0;
        bus.wb_rd_addr_i   = 5'd0;
        bus.wb_rd_wdata_i  = 32'd0;
        bus.wb_mem_rdata_i = 32'd0;
        bus.flush_i        = 1'b0;
    endtask

    function automatic rvfi_issue_t mk_issue(logic [31:0] pc, logic [31:0] insn, logic trap);
        rvfi_issue_t r;
        r.pc_rdata  = pc;
        r.pc_wdata  = pc + 32'd4;
        r.insn      = insn;
        r.trap      = trap;
        r.rs1_addr  = 5'($urandom_range(0, 31));
        r.rs2_addr  = 5'($urandom_range(0, 31));
        r.rs3_addr  = 5'($urandom_range(0, 31));
        r.rs1_rdata = $urandom;
        r.rs2_rdata = $urandom;
        r.rs3_rdata = $urandom;
        r.mem_addr  = $urandom;
        r.mem_rmask = 4'($urandom_range(0, 15));
        r.mem_wmask = 4'($urandom_range(0, 15));
        r.mem_wdata = $urandom;
        return r;
    endfunction

    // What the tracer should see when instruction h retires with the given writeback.
    function automatic rvfi_rec_t model_rec(rvfi_issue_t h, logic [4:0] wa, logic [31:0] wd,
                                            logic [31:0] mrd);
        rvfi_rec_t r;
        r           = '0;
        r.insn      = h.insn;
        r.trap      = h.trap;
        r.mode      = 2'b11;
        r.ixl       = 2'b01;
        r.rs1_addr  = h.rs1_addr;
        r.rs2_addr  = h.rs2_addr;
        r.rs3_addr  = h.rs3_addr;
        r.rs1_rdata = h.rs1_rdata;
        r.rs2_rdata = h.rs2_rdata;
        r.rs3_rdata = h.rs3_rdata;
        r.pc_rdata  = h.pc_rdata;
        r.pc_wdata  = h.pc_wdata;
        if (!h.trap) begin
            r.rd_addr  = wa;
            r.rd_wdata = (wa == 5'd0) ? 32'd0 : wd;
        end
`ifdef RVFI_MEM_EN
        r.mem_addr  = h.mem_addr;
        r.mem_rmask = h.mem_rmask;
        r.mem_wmask = h.mem_wmask;
        r.mem_wdata = h.mem_wdata;
        r.mem_rdata = h.trap ? 32'd0 : mrd;
`else
        r.mem_rdata = (mrd === 32'hx) ? 32'd0 : 32'd0;
`endif
        return r;
    endfunction

    // Apply the current inputs for one clock edge to both the model and the DUT, then compare.
    task automatic tick();
        int n;
        bit htrap;
        bit ret;
        n = pend.size();
        if (rst_n) chk("ready", bus.issue_ready_o, (n < DEPTH));
        if (!rst_n) begin
            pend.delete();
            m_err       = 0;
            m_ord       = '0;
            m_order_out = '0;
            m_rec       = '0;
            m_valid     = 0;
        end else begin
            htrap = (n > 0) && pend[0].trap;
            ret   = (n > 0) && (bus.wb_valid_i || htrap);
            if (bus.wb_valid_i && (n == 0 || htrap)) m_err = 1;
            if (ret) begin
                m_rec       = model_rec(pend[0], bus.wb_rd_addr_i, bus.wb_rd_wdata_i, bus.wb_mem_rdata_i);
                m_order_out = m_ord;
                m_ord       = m_ord + 64'd1;
                void'(pend.pop_front());
            end
            m_valid = ret;
            if (bus.flush_i) pend.delete();
            else if (bus.issue_valid_i && n < DEPTH) pend.push_back(bus.issue_rec_i);
        end
        @(posedge clk);
        #1;
        chk("valid", bus.rvfi_valid_o, m_valid);
        chk("err", bus.err_o, m_err);
        chk("order", bus.rvfi_order_o, m_order_out);
        chk("rec", bus.rvfi_rec_o, m_rec);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready", bus.issue_ready_o, 1);
        chk("rst_valid", bus.rvfi_valid_o, 0);
        chk("rst_order", bus.rvfi_order_o, 0);
        chk("rst_rec", bus.rvfi_rec_o, 0);
        chk("rst_err", bus.err_o, 0);

        // Single instruction then its writeback.
        bus.issue_valid_i = 1'b1;
        bus.issue_rec_i   = mk_issue(32'h80, 32'h00500093, 1'b0);
        tick();
        idle_inputs();
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_addr_i  = 5'd1;
        bus.wb_rd_wdata_i = 32'd5;
        tick();
        chk("basic_valid", bus.rvfi_valid_o, 1);
        chk("basic_order", bus.rvfi_order_o, 0);
        chk("basic_pc", bus.rvfi_rec_o.pc_rdata, 32'h80);
        chk("basic_insn", bus.rvfi_rec_o.insn, 32'h00500093);
        chk("basic_rd_wdata", bus.rvfi_rec_o.rd_wdata, 32'd5);
        chk("basic_mode", bus.rvfi_rec_o.mode, 2'b11);
        idle_inputs();
        tick();
        chk("basic_strobe_drop", bus.rvfi_valid_o, 0);

        // Back-pressure: third issue waits for a retirement, and not in the wb cycle itself.
        bus.issue_valid_i = 1'b1;
        bus.issue_rec_i   = mk_issue(32'h100, $urandom, 1'b0);
        tick();
        bus.issue_rec_i   = mk_issue(32'h104, $urandom, 1'b0);
        tick();
        chk("bp_full", bus.issue_ready_o, 0);
        bus.issue_rec_i   = mk_issue(32'h108, $urandom, 1'b0);
        tick();
        chk("bp_still_full", bus.issue_ready_o, 0);
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_addr_i  = 5'd2;
        bus.wb_rd_wdata_i = $urandom;
        tick();
        chk("bp_ready_after_wb", bus.issue_ready_o, 1);
        bus.wb_valid_i    = 1'b0;
        tick();
        bus.issue_valid_i = 1'b0;
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_wdata_i = $urandom;
        tick();
        tick();
        chk("bp_third_pc", bus.rvfi_rec_o.pc_rdata, 32'h108);
        idle_inputs();
        tick();

        // Trap retires without writeback; a stray wb afterwards is a protocol error.
        bus.issue_valid_i = 1'b1;
        bus.issue_rec_i   = mk_issue(32'h200, 32'h00000073, 1'b1);
        tick();
        idle_inputs();
        tick();
        chk("trap_valid", bus.rvfi_valid_o, 1);
        chk("trap_rd_addr", bus.rvfi_rec_o.rd_addr, 0);
        chk("trap_rd_wdata", bus.rvfi_rec_o.rd_wdata, 0);
        chk("trap_flag", bus.rvfi_rec_o.trap, 1);
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_addr_i  = 5'd3;
        bus.wb_rd_wdata_i = 32'd7;
        tick();
        chk("trap_err", bus.err_o, 1);
        chk("trap_wb_ignored", bus.rvfi_valid_o, 0);
        idle_inputs();
        tick();
        chk("err_sticky", bus.err_o, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("err_cleared", bus.err_o, 0);

        // Writes to x0 report zero data.
        bus.issue_valid_i = 1'b1;
        bus.issue_rec_i   = mk_issue(32'h300, $urandom, 1'b0);
        tick();
        idle_inputs();
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_addr_i  = 5'd0;
        bus.wb_rd_wdata_i = 32'hDEAD;
        tick();
        chk("rd0_valid", bus.rvfi_valid_o, 1);
        chk("rd0_wdata", bus.rvfi_rec_o.rd_wdata, 0);
        idle_inputs();
        tick();

        // Flush with a simultaneous retirement: only the head retires.
        bus.issue_valid_i = 1'b1;
        bus.issue_rec_i   = mk_issue(32'h400, $urandom, 1'b0);
        tick();
        bus.issue_rec_i   = mk_issue(32'h404, $urandom, 1'b0);
        tick();
        n_save            = m_ord;
        bus.issue_rec_i   = mk_issue(32'h408, $urandom, 1'b0);
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_addr_i  = 5'd4;
        bus.wb_rd_wdata_i = $urandom;
        bus.flush_i       = 1'b1;
        tick();
        chk("flush_valid", bus.rvfi_valid_o, 1);
        chk("flush_order", bus.rvfi_order_o, n_save);
        chk("flush_pc", bus.rvfi_rec_o.pc_rdata, 32'h400);
        chk("flush_count", dut.u_fifo.count_o, 0);
        idle_inputs();
        tick();
        chk("flush_no_more", bus.rvfi_valid_o, 0);
        bus.issue_valid_i = 1'b1;
        bus.issue_rec_i   = mk_issue(32'h500, $urandom, 1'b0);
        tick();
        idle_inputs();
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_addr_i  = 5'd5;
        bus.wb_rd_wdata_i = $urandom;
        tick();
        chk("post_flush_order", bus.rvfi_order_o, n_save + 64'd1);
        chk("post_flush_pc", bus.rvfi_rec_o.pc_rdata, 32'h500);
        idle_inputs();

        // Order counter wraps modulo 2^64.
        force dut.order_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_ord = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        release dut.order_cnt_q;
        for (int k = 0; k < 2; k++) begin
            bus.issue_valid_i = 1'b1;
            bus.issue_rec_i   = mk_issue(32'h600 + 32'(4 * k), $urandom, 1'b0);
            bus.wb_valid_i    = 1'b0;
            tick();
            bus.issue_valid_i = 1'b0;
            bus.wb_valid_i    = 1'b1;
            bus.wb_rd_addr_i  = 5'(k + 6);
            bus.wb_rd_wdata_i = $urandom;
            tick();
            chk("wrap_order", bus.rvfi_order_o, (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
        end
        idle_inputs();

        // Reset with instructions in flight discards them without a retirement.
        bus.issue_valid_i = 1'b1;
        bus.issue_rec_i   = mk_issue(32'h700, $urandom, 1'b0);
        tick();
        bus.issue_rec_i   = mk_issue(32'h704, $urandom, 1'b0);
        tick();
        bus.issue_valid_i = 1'b0;
        bus.wb_valid_i    = 1'b1;
        bus.wb_rd_addr_i  = 5'd9;
        bus.wb_rd_wdata_i = $urandom;
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", bus.rvfi_valid_o, 0);
        chk("midrst_err", bus.err_o, 0);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready", bus.issue_ready_o, 1);
        chk("midrst_quiet", bus.rvfi_valid_o, 0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            bus.issue_valid_i  = ($urandom_range(0, 2) != 0);
            tmp                = mk_issue($urandom, $urandom, ($urandom_range(0, 7) == 0));
            bus.issue_rec_i    = tmp;
            if (pend.size() > 0 && !pend[0].trap) bus.wb_valid_i = 1'($urandom_range(0, 1));
            else bus.wb_valid_i = ($urandom_range(0, 31) == 0);
            bus.wb_rd_addr_i   = 5'($urandom_range(0, 31));
            bus.wb_rd_wdata_i  = $urandom;
            bus.wb_mem_rdata_i = $urandom;
            bus.flush_i        = ($urandom_range(0, 29) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
